// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM state encoding and default multi-cycle timeout for hazard_ctrl
package hazard_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;
  localparam int MC_TIMEOUT_DEF = 64;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping 32-bit counters of stall cycles, flush cycles and MC_WAIT entries (in clk, reset, stall, flush, mc_entry; out stall_cnt, flush_cnt, mc_cnt)
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        mc_entry,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] mc_cnt
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      mc_cnt    <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(stall);
      flush_cnt <= flush_cnt + 32'(flush);
      mc_cnt    <= mc_cnt + 32'(mc_entry);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, branch and multi-cycle hazards; in clk, reset, rs*/rd_e/load_e/branch_sig/mc_start/mc_done; out stallF/D/E, flushD/E, err_o, plus stall_cnt/flush_cnt/mc_cnt under HAZARD_PERF_CNT_EN
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       rs1_valid_d,
  input  logic       rs2_valid_d,
  input  logic [4:0] rd_e,
  input  logic       load_e,
  input  logic       branch_sig,
  input  logic       mc_start,
  input  logic       mc_done,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] mc_cnt
`endif
);
  localparam int CW = MC_TIMEOUT > 1 ? $clog2(MC_TIMEOUT) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic load_use, in_wait, timeout;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_o <= err_o | timeout;
    end
  always_comb begin
    load_use = load_e & (rd_e != 5'd0) &
               ((rs1_valid_d & (rs1_d == rd_e)) | (rs2_valid_d & (rs2_d == rd_e)));
    in_wait  = state == MC_WAIT;
    timeout  = in_wait & ~mc_done & (cnt == CW'(MC_TIMEOUT - 1));
    state_n  = in_wait ? ((mc_done | timeout) ? RUN : MC_WAIT)
                       : ((mc_start & ~mc_done) ? MC_WAIT : RUN);
    cnt_n    = (in_wait & ~mc_done & ~timeout) ? cnt + CW'(1) : '0;
    stallF   = in_wait | (~branch_sig & load_use);
    stallD   = stallF;
    stallE   = in_wait;
    flushD   = ~in_wait & branch_sig;
    flushE   = ~in_wait & (branch_sig | load_use);
  end
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk      (clk),
    .reset    (reset),
    .stall    (stallF),
    .flush    (flushD),
    .mc_entry (~in_wait & (state_n == MC_WAIT)),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .mc_cnt   (mc_cnt)
  );
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector and sequence bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic rs1_valid_d, rs2_valid_d, load_e, branch_sig, mc_start, mc_done;
  logic stallF, stallD, stallE, flushD, flushE, err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, mc_cnt;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MC_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_valid_d(rs1_valid_d), .rs2_valid_d(rs2_valid_d), .rd_e(rd_e),
    .load_e(load_e), .branch_sig(branch_sig), .mc_start(mc_start), .mc_done(mc_done),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD),
    .flushE(flushE), .err_o(err_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mc_cnt(mc_cnt)
`endif
  );
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic v1, v2, ld, br, mcs, mcd;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [4:0] outs();
    return {stallF, stallD, stallE, flushD, flushE};
  endfunction
  task automatic idle();
    {rs1_d, rs2_d, rd_e} = '0;
    {rs1_valid_d, rs2_valid_d, load_e, branch_sig, mc_start, mc_done} = '0;
  endtask
  initial begin
    int n;
    vecs[0]  = '{5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 5'b00000};
    vecs[1]  = '{5'd5,  5'd0, 5'd5,  1, 0, 1, 0, 0, 0, 5'b11001};
    vecs[2]  = '{5'd5,  5'd0, 5'd5,  0, 0, 1, 0, 0, 0, 5'b00000};
    vecs[3]  = '{5'd0,  5'd0, 5'd0,  1, 1, 1, 0, 0, 0, 5'b00000};
    vecs[4]  = '{5'd1,  5'd5, 5'd5,  1, 1, 1, 0, 0, 0, 5'b11001};
    vecs[5]  = '{5'd1,  5'd5, 5'd5,  1, 0, 1, 0, 0, 0, 5'b00000};
    vecs[6]  = '{5'd5,  5'd0, 5'd5,  1, 0, 1, 1, 0, 0, 5'b00011};
    vecs[7]  = '{5'd0,  5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 5'b00011};
    vecs[8]  = '{5'd5,  5'd5, 5'd5,  1, 1, 0, 0, 0, 0, 5'b00000};
    vecs[9]  = '{5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 1, 1, 5'b00000};
    vecs[10] = '{5'd0,  5'd0, 5'd0,  0, 0, 0, 1, 1, 1, 5'b00011};
    vecs[11] = '{5'd31, 5'd2, 5'd31, 1, 0, 1, 0, 0, 0, 5'b11001};
    idle();
    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rs1_d = vecs[i].rs1; rs2_d = vecs[i].rs2; rd_e = vecs[i].rd;
      rs1_valid_d = vecs[i].v1; rs2_valid_d = vecs[i].v2; load_e = vecs[i].ld;
      branch_sig = vecs[i].br; mc_start = vecs[i].mcs; mc_done = vecs[i].mcd;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    @(negedge clk) idle();
    rs1_d = 5'd5; rd_e = 5'd5; rs1_valid_d = 1; load_e = 1;
    #1 chk("lu_cycle", 32'(outs()), 32'b11001);
    @(negedge clk) load_e = 0;
    #1 chk("lu_release", 32'(outs()), 32'd0);
    @(negedge clk) idle();
    mc_start = 1;
    #1 chk("mc_issue", 32'(outs()), 32'd0);
    @(negedge clk) mc_start = 0; branch_sig = 1;
    #1 chk("mc_wait1", 32'(outs()), 32'b11100);
    @(negedge clk) branch_sig = 0;
    #1 chk("mc_wait2", 32'(outs()), 32'b11100);
    @(negedge clk) mc_done = 1;
    #1 chk("mc_wait3_done", 32'(outs()), 32'b11100);
    @(negedge clk) mc_done = 0;
    #1 chk("mc_back_run", 32'(outs()), 32'd0);
    chk("mc_no_err", 32'(err_o), 32'd0);
    @(negedge clk) mc_start = 1;
    @(negedge clk) mc_start = 0;
    n = 0;
    #1;
    chk("to_err_early", 32'(err_o), 32'd0);
    for (int i = 0; i < 20 && stallE; i++) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("to_stall_cycles", n, 8);
    chk("to_run", 32'(outs()), 32'd0);
    chk("to_err_set", 32'(err_o), 32'd1);
    repeat (3) @(negedge clk);
    rs1_d = 5'd5; rd_e = 5'd5; rs1_valid_d = 1; load_e = 1;
    #1 chk("err_sticky", 32'(err_o), 32'd1);
    chk("err_no_effect", 32'(outs()), 32'b11001);
    @(negedge clk) idle();
    mc_start = 1;
    @(negedge clk) mc_start = 0;
    #1 chk("rst_pre_stall", 32'(outs()), 32'b11100);
    #2 reset = 1'b0;
    #1 chk("rst_async_outs", 32'(outs()), 32'd0);
    chk("rst_async_err", 32'(err_o), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_cnts", stall_cnt | flush_cnt | mc_cnt, 32'd0);
`endif
    @(negedge clk) reset = 1'b1;
    #1 chk("rst_after_outs", 32'(outs()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MC_TIMEOUT, default 64; max cycles spent in MC_WAIT before forced exit.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low.
REQ-004 rs1_d, rs2_d  input  5 each  source register indices of the instruction in D.
REQ-005 rs1_valid_d, rs2_valid_d  input  1 each  corresponding source is actually read.
REQ-006 rd_e  input  5  destination index of the instruction in E.
REQ-007 load_e  input  1  instruction in E is a load.
REQ-008 branch_sig  input  1  taken branch/jump resolved in E; same signal the fetch stage consumes.
REQ-009 mc_start  input  1  multi-cycle op issues from E this cycle.
REQ-010 mc_done  input  1  multi-cycle unit result ready.
REQ-011 stallF, stallD, stallE  output  1 each  hold the F, D and E pipeline registers.
REQ-012 flushD, flushE  output  1 each  convert D or E contents to a bubble at the next edge.
REQ-013 err_o  output  1  sticky multi-cycle timeout flag.

Function
REQ-014 FSM states: RUN, MC_WAIT; all stall/flush outputs are combinational from state and current inputs.
REQ-015 load_use = load_e & (rd_e!=0) & ((rs1_valid_d & rs1_d==rd_e) | (rs2_valid_d & rs2_d==rd_e)).
REQ-016 RUN, branch_sig=1: flushD=1, flushE=1, no stall; load_use ignored in that cycle.
REQ-017 RUN, branch_sig=0, load_use=1: stallF=stallD=1, flushE=1 for exactly one cycle; no state change.
REQ-018 RUN, mc_start=1, mc_done=0: next state MC_WAIT; the issue cycle itself produces no stall.
REQ-019 RUN, mc_start=1, mc_done=1 in the same cycle: treated as single-cycle; state stays RUN.
REQ-020 mc_start together with branch_sig: both honoured; the flush outputs of REQ-016 apply, and the state change of REQ-018/019 applies.
REQ-021 MC_WAIT: stallF=stallD=stallE=1, flushD=flushE=0; branch_sig and load_use are ignored.
REQ-022 MC_WAIT, mc_done=1: stalls are still asserted in that cycle; next state is RUN.
REQ-023 Wait counter: width clog2(MC_TIMEOUT); cleared on entry to MC_WAIT; increments each MC_WAIT cycle without mc_done.
REQ-024 Counter at MC_TIMEOUT-1 with mc_done=0: next state RUN; err_o set; counter must not wrap.
REQ-025 err_o is sticky until reset; it does not affect stall/flush behaviour.

Reset
REQ-026 reset=0 forces state=RUN, counter=0 and err_o=0 immediately (asynchronous), including in the middle of an MC_WAIT.
REQ-027 During reset with all inputs 0, every output is 0.

Configuration
REQ-028 With HAZARD_PERF_CNT_EN defined, three extra outputs exist, each 32-bit and reset to 0, wrapping modulo 2^32:
- stall_cnt: counts cycles with stallF=1.
- flush_cnt: counts cycles with flushD=1.
- mc_cnt: counts MC_WAIT entries.
REQ-029 Without HAZARD_PERF_CNT_EN, these outputs and their registers do not exist; all other behaviour is identical.

Structure
REQ-030 The state encoding (RUN=0, MC_WAIT=1) and the default MC_TIMEOUT belong in the shared define file; the register-compare logic stays local.
REQ-031 One sub-module, hazard_perf_cnt, holds the counters of REQ-028 and is instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-032 load_e=1, rd_e=5, rs1_d=5, rs1_valid_d=1 -> one cycle of stallF=stallD=flushE=1; outputs 0 on the next cycle once load_e=0.
REQ-033 Same as REQ-032 but rd_e=0, or rs1_valid_d=0 -> no stall and no flush.
REQ-034 branch_sig=1 together with a load-use match -> flushD=flushE=1, stallF=0.
REQ-035 mc_start pulse, then mc_done raised 3 cycles later -> stallF/D/E high for exactly 3 cycles, then RUN.
REQ-036 MC_TIMEOUT=8, mc_start with mc_done never raised -> 8 stall cycles, then RUN and err_o=1; err_o stays 1 until reset is pulsed.
REQ-037 reset pulsed mid-MC_WAIT -> stalls drop immediately, err_o=0; with HAZARD_PERF_CNT_EN, counters read 0.
